fpu_stream_core: RTL and testbench
==================================

# fpu_stream_core

Streaming, parametrised single-precision FPU core with valid/ready handshakes on both sides, an input command FIFO and a configurable-depth result pipeline. It reuses the team's combinational add/sub, multiply and divide units and carries a per-command tag so that results can be matched to requests. It sits between the instruction issue logic and the writeback/result bus, and replaces the single-register, no-handshake FPU core. Results are returned in order, with throughput of one command per cycle.

## Interface
- DEPTH, 4: input command FIFO entries; power of two, ≥2
- LATENCY, 2: result pipeline register stages after the arithmetic units; ≥1
- TAG_W, 4: width of the request tag carried with each command

- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept a command
- a_operand  in  32  IEEE-754 single operand A
- b_operand  in  32  IEEE-754 single operand B
- Operation  in  4  0 add, 1 sub (A−B), 2 mul, 3 div; all other codes are illegal
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- FPU_Output  out  32  result
- Exception  out  1  unit exception flag
- Overflow  out  1  multiply overflow; 0 for all other operations
- Underflow  out  1  multiply underflow; 0 for all other operations
- Illegal  out  1  Operation code was greater than 3
- out_tag  out  TAG_W  tag of the result
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
- flag_clr  in  1  clears the sticky flags
- sticky_flags  out  4  {Illegal, Underflow, Overflow, Exception}, each accumulated by OR

## Operation
- Accept: a command is accepted on a rising edge where in_valid && in_ready. in_ready = (fifo_count != DEPTH).
- in_ready is registered state only. It does not depend combinationally on out_ready. A full FIFO refuses a push even on a cycle where it pops.
- Issue: the FIFO head feeds the arithmetic units combinationally. The head is popped into stage S1 when the FIFO is non-empty and the pipe enables.
- Pipe enable: adv = !S_LATENCY.valid || out_ready. Every stage shifts on adv; all stages hold when adv is low. Bubbles are not collapsed.
- Each stage holds valid, result, Exception, Overflow, Underflow, Illegal and tag. The output ports are driven directly from stage S_LATENCY.
- Illegal operation: FPU_Output=0, Exception=1, Illegal=1, Overflow=0, Underflow=0. The operation still occupies a slot and returns its tag.
- Unit multiplexing: only the selected unit's outputs are used. The operands of the non-selected units are driven to 0; there are no tristate nets.
- FIFO: pointers of width $clog2(DEPTH) wrap modulo DEPTH. Occupancy changes as follows:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Sticky flags: sticky_flags |= the flags of each result on a handshake cycle (out_valid && out_ready).
  - flag_clr zeros the register.
  - If flag_clr and a handshake occur in the same cycle, the new result's flags are kept (clear first, then OR).
- Reset (Rst high, asynchronous):
  - FIFO pointers and count = 0; all stage valids = 0
  - FPU_Output, flags, out_tag = 0; sticky_flags = 0
  - in_ready = 1 once Rst is low
- Reset mid-operation discards all queued and in-flight commands. No result is emitted for them.

## Timing
- Latency with the pipe empty and out_ready=1: out_valid rises LATENCY+1 rising edges after the accepting edge (one edge for the FIFO write, then LATENCY stage edges).
- Throughput: one result per cycle while in_valid=1 and out_ready=1.
- Backpressure: with out_ready held low, the FIFO fills after DEPTH+LATENCY accepted commands, then in_ready drops. Output data stays stable while out_valid && !out_ready.
- When out_ready rises again, in_ready returns one cycle after the first pop.

## Configuration
- FPU_STICKY_FLAGS_EN defined: the sticky flag register and flag_clr behave as described above.
- Not defined: sticky_flags is tied to 4'b0, flag_clr is ignored, and no sticky register is synthesised.

## Test plan
- Add: 0x3FC00000 + 0x40100000 (1.5 + 2.25), tag 3, LATENCY=2, out_ready=1 → out_valid 3 edges after accept; FPU_Output=0x40700000, out_tag=3, all flags 0.
- Back-to-back stream: sub 0x40100000−0x3FC00000, mul 0x40400000×0x40000000, div 0x40C00000/0x40000000 on consecutive cycles → results 0x3F400000, 0x40C00000, 0x40400000 on consecutive cycles, in order with matching tags.
- Backpressure: out_ready=0 with DEPTH=4, LATENCY=2 → exactly 6 commands accepted, then in_ready=0 and the output stable. Raise out_ready → all 6 results drain in order with no loss or duplication.
- Illegal op: Operation=7 → FPU_Output=0, Exception=1, Illegal=1. With FPU_STICKY_FLAGS_EN, sticky_flags=4'b1001 until flag_clr.
- Multiply overflow: 0x7F000000 × 0x7F000000 → Overflow=1 and sticky Overflow set. A flag_clr asserted on the same handshake cycle leaves sticky Overflow at 1.
- Reset mid-flight: assert Rst with 3 commands queued and 2 in the pipe → out_valid=0, fifo_count=0 and outputs 0 immediately. After release, no stale result appears and a new command returns correctly.

Source files
------------

// File: rtl/fpu_stream_core.sv
// Streaming single-precision FPU: command FIFO, add/sub/mul/div units, tagged in-order result pipeline.
// Define FPU_STICKY_FLAGS_EN to build the sticky flag register driven by flag_clr.
module fpu_stream_core #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             a_operand,
  input  logic [31:0]             b_operand,
  input  logic [3:0]              Operation,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             FPU_Output,
  output logic                    Exception,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Illegal,
  output logic [TAG_W-1:0]        out_tag,
  output logic [$clog2(DEPTH):0]  fifo_count,
  input  logic                    flag_clr,
  output logic [3:0]              sticky_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      res;
    logic             exc;
    logic             ovf;
    logic             unf;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Truncating add; denormals flush to zero. Returns {exception, result}.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [26:0]        mx, my;
    logic [27:0]        s;
    logic [7:0]         d;
    logic signed [9:0]  e;
    int unsigned        p;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC00000};
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    mx = (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? '0 : {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    my = (d > 8'd26) ? '0 : my >> d;
    s  = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
    if (s == '0) return '0;
    p = 0;
    for (int unsigned i = 0; i < 28; i++) if (s[i]) p = i;
    e = $signed({2'b00, x[30:23]}) + $signed(10'(p)) - 10'sd26;
    if (p > 26) s = s >> 1;
    else        s = s << (26 - p);
    if (e <= 10'sd0)   return {1'b0, x[31], 31'd0};
    if (e >= 10'sd255) return {1'b0, x[31], 8'hFF, 23'd0};
    return {1'b0, x[31], e[7:0], s[25:3]};
  endfunction

  // Returns {exception, overflow, underflow, result}.
  function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        prod;
    logic [24:0]        mt;
    logic signed [10:0] e;
    logic               sg;
    sg = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, 32'h7FC00000};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)   return {3'b000, sg, 31'd0};
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    mt   = 25'(prod >> 23);
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127
        + (mt[24] ? 11'sd1 : 11'sd0);
    if (e >= 11'sd255) return {3'b010, sg, 8'hFF, 23'd0};
    if (e <= 11'sd0)   return {3'b001, sg, 31'd0};
    return {3'b000, sg, e[7:0], (mt[24] ? mt[23:1] : mt[22:0])};
  endfunction

  // Returns {exception, result}; divide by zero gives signed infinity with exception.
  function automatic logic [32:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic [24:0]        q;
    logic signed [10:0] e;
    logic               sg;
    sg = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC00000};
    if (b[30:23] == 8'd0) return {1'b1, sg, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0) return {1'b0, sg, 31'd0};
    q = 25'({1'b1, a[22:0], 24'd0} / 48'({1'b1, b[22:0]}));
    e = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127
        - (q[24] ? 11'sd0 : 11'sd1);
    if (e >= 11'sd255) return {1'b0, sg, 8'hFF, 23'd0};
    if (e <= 11'sd0)   return {1'b0, sg, 31'd0};
    return {1'b0, sg, e[7:0], (q[24] ? q[23:1] : q[22:0])};
  endfunction

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, adv;
  cmd_t          hd;
  stage_t        st [LATENCY];
  stage_t        issue;
  logic [31:0]   add_a, add_b, mul_a, mul_b, div_a, div_b;
  logic [32:0]   add_r, div_r;
  logic [34:0]   mul_r;

  assign adv      = !st[LATENCY-1].valid || out_ready;
  assign in_ready = (fifo_count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (fifo_count != '0) && adv;
  assign hd       = mem[rd_ptr];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= '{a: a_operand, b: b_operand, op: Operation, tag: in_tag};
  end

  always_comb begin
    add_a = '0; add_b = '0;
    mul_a = '0; mul_b = '0;
    div_a = '0; div_b = '0;
    case (hd.op)
      4'd0, 4'd1: begin
        add_a = hd.a;
        add_b = {hd.b[31] ^ hd.op[0], hd.b[30:0]};
      end
      4'd2: begin mul_a = hd.a; mul_b = hd.b; end
      4'd3: begin div_a = hd.a; div_b = hd.b; end
      default: ;
    endcase
  end

  assign add_r = fp_add(add_a, add_b);
  assign mul_r = fp_mul(mul_a, mul_b);
  assign div_r = fp_div(div_a, div_b);

  always_comb begin
    issue       = '0;
    issue.valid = pop;
    issue.tag   = hd.tag;
    case (hd.op)
      4'd0, 4'd1: {issue.exc, issue.res} = add_r;
      4'd2:       {issue.exc, issue.ovf, issue.unf, issue.res} = mul_r;
      4'd3:       {issue.exc, issue.res} = div_r;
      default: begin
        issue.exc = 1'b1;
        issue.ill = 1'b1;
      end
    endcase
    if (!pop) issue = '0;
  end

  // Whole pipe moves in lockstep; bubbles travel with it rather than being squeezed out.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) st[i] <= '0;
    end else if (adv) begin
      st[0] <= issue;
      for (int unsigned i = 1; i < LATENCY; i++) st[i] <= st[i-1];
    end
  end

  assign out_valid  = st[LATENCY-1].valid;
  assign FPU_Output = st[LATENCY-1].res;
  assign Exception  = st[LATENCY-1].exc;
  assign Overflow   = st[LATENCY-1].ovf;
  assign Underflow  = st[LATENCY-1].unf;
  assign Illegal    = st[LATENCY-1].ill;
  assign out_tag    = st[LATENCY-1].tag;

`ifdef FPU_STICKY_FLAGS_EN
  logic [3:0] sticky_q;
  logic       hs;
  logic [3:0] res_flags;

  assign hs        = out_valid && out_ready;
  assign res_flags = {Illegal, Underflow, Overflow, Exception};

  // Clear takes effect before the OR, so a result handed over on the clear cycle is kept.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)           sticky_q <= '0;
    else if (flag_clr) sticky_q <= hs ? res_flags : '0;
    else if (hs)       sticky_q <= sticky_q | res_flags;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = '0;
`endif

endmodule

// File: tb/tb_fpu_stream_core.sv
// Scoreboard bench for fpu_stream_core: expected results queued on accept, compared on output handshake.
module tb_fpu_stream_core;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 4;

  logic                   Clk = 1'b0;
  logic                   Rst;
  logic                   in_valid, in_ready;
  logic [31:0]            a_operand, b_operand;
  logic [3:0]             Operation;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid, out_ready;
  logic [31:0]            FPU_Output;
  logic                   Exception, Overflow, Underflow, Illegal;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   flag_clr;
  logic [3:0]             sticky_flags;

  fpu_stream_core #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .Operation(Operation), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .FPU_Output(FPU_Output), .Exception(Exception), .Overflow(Overflow),
    .Underflow(Underflow), .Illegal(Illegal), .out_tag(out_tag),
    .fifo_count(fifo_count), .flag_clr(flag_clr), .sticky_flags(sticky_flags)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic [3:0]       fl;        // {ill, unf, ovf, exc}
    logic             exc_known;
    logic             lat;
    logic             b2b;
    int               acc;
  } tc_t;

  tc_t sb[$];
  tc_t cur;
  tc_t mon_e;
  tc_t tbl[9];
  int  nchecks = 0;
  int  nerrs   = 0;
  int  cyc     = 0;
  int  last_pop = -10;
  int  npop    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nchecks++;
    if (got !== want) begin
      nerrs++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic tc_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             input logic [TAG_W-1:0] tag, input logic [31:0] res,
                             input logic [3:0] fl, input logic exc_known);
    tc_t t;
    t.a = a; t.b = b; t.op = op; t.tag = tag; t.res = res; t.fl = fl;
    t.exc_known = exc_known; t.lat = 1'b0; t.b2b = 1'b0; t.acc = 0;
    return t;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Outputs and handshakes sampled mid-cycle; the handshake itself completes on the next rising edge.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result", FPU_Output, mon_e.res);
          check("tag", 32'(out_tag), 32'(mon_e.tag));
          check("illegal", 32'(Illegal), 32'(mon_e.fl[3]));
          check("underflow", 32'(Underflow), 32'(mon_e.fl[2]));
          check("overflow", 32'(Overflow), 32'(mon_e.fl[1]));
          if (mon_e.exc_known) check("exception", 32'(Exception), 32'(mon_e.fl[0]));
          // acc is the accepting edge itself, which counts as the first of LATENCY+1 edges
          if (mon_e.lat) check("latency", 32'(cyc - mon_e.acc), LATENCY);
          if (mon_e.b2b) check("throughput", 32'(cyc - last_pop), 32'd1);
          last_pop = cyc;
          npop++;
        end
      end
      if (in_valid && in_ready) begin
        mon_e = cur;
        mon_e.acc = cyc + 1;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send(input tc_t c);
    int unsigned n;
    a_operand = c.a; b_operand = c.b; Operation = c.op; in_tag = c.tag;
    cur = c;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", nchecks, nerrs);
    $fatal(1);
  end

  initial begin
    logic [3:0]  exp_sticky;
    int          acc;
    int          np0;
    int unsigned n;
    tc_t         t;

`ifdef FPU_STICKY_FLAGS_EN
    exp_sticky = 4'b1001;
`else
    exp_sticky = 4'b0000;
`endif

    Rst = 1'b1; in_valid = 1'b0; a_operand = '0; b_operand = '0; Operation = '0;
    in_tag = '0; out_ready = 1'b1; flag_clr = 1'b0;
    tick(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_output", FPU_Output, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    Rst = 1'b0;
    tick(1);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // single add with empty pipe: latency check
    t = mk(32'h3FC00000, 32'h40100000, 4'd0, 4'd3, 32'h40700000, 4'b0000, 1'b1);
    t.lat = 1'b1;
    send(t);
    in_valid = 1'b0;
    drain("add_drain");

    // back-to-back stream
    tbl[0] = mk(32'h40100000, 32'h3FC00000, 4'd1, 4'd1, 32'h3F400000, 4'b0000, 1'b1);
    tbl[1] = mk(32'h40400000, 32'h40000000, 4'd2, 4'd2, 32'h40C00000, 4'b0000, 1'b1);
    tbl[2] = mk(32'h40C00000, 32'h40000000, 4'd3, 4'd4, 32'h40400000, 4'b0000, 1'b1);
    tbl[3] = mk(32'h3F800000, 32'h3F800000, 4'd0, 4'd5, 32'h40000000, 4'b0000, 1'b1);
    tbl[4] = mk(32'h3FC00000, 32'h40100000, 4'd1, 4'd6, 32'hBF400000, 4'b0000, 1'b1);
    tbl[5] = mk(32'h3F800000, 32'h40000000, 4'd3, 4'd7, 32'h3F000000, 4'b0000, 1'b1);
    tbl[6] = mk(32'h40000000, 32'h40000000, 4'd2, 4'd8, 32'h40800000, 4'b0000, 1'b1);
    tbl[7] = mk(32'h00800000, 32'h00800000, 4'd2, 4'd9, 32'h00000000, 4'b0100, 1'b0);
    tbl[8] = mk(32'h3FC00000, 32'hBFC00000, 4'd0, 4'd10, 32'h00000000, 4'b0000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      t = tbl[i];
      t.b2b = (i != 0);
      send(t);
    end
    in_valid = 1'b0;
    drain("stream_drain");

    // backpressure: 1.0 * v gives v exactly
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      t = mk(32'h3F800000, 32'h40000000 + (i << 20), 4'd2, 4'(i), 32'h40000000 + (i << 20),
             4'b0000, 1'b1);
      a_operand = t.a; b_operand = t.b; Operation = t.op; in_tag = t.tag;
      cur = t;
      in_valid = 1'b1;
      @(negedge Clk);
      if (in_ready) acc++;
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), DEPTH + LATENCY);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_fifo_count", 32'(fifo_count), DEPTH);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    tick(3);
    check("bp_stable_data", FPU_Output, sb[0].res);
    check("bp_stable_tag", 32'(out_tag), 32'(sb[0].tag));
    np0 = npop;
    out_ready = 1'b1;
    @(negedge Clk);
    check("bp_ready_before_pop", 32'(in_ready), 32'd0);
    @(negedge Clk);
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
    drain("bp_drain");
    check("bp_drained", 32'(npop - np0), DEPTH + LATENCY);

    // illegal op and sticky flags
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    send(mk(32'h3F800000, 32'h3F800000, 4'd7, 4'd5, 32'h00000000, 4'b1001, 1'b1));
    in_valid = 1'b0;
    drain("ill_drain");
    check("sticky_ill", 32'(sticky_flags), 32'(exp_sticky));
    tick(2);
    check("sticky_hold", 32'(sticky_flags), 32'(exp_sticky));
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    check("sticky_clr", 32'(sticky_flags), 32'd0);

    // overflow result handed over on the same cycle as a clear
    send(mk(32'h3F800000, 32'h3F800000, 4'd7, 4'd6, 32'h00000000, 4'b1001, 1'b1));
    in_valid = 1'b0;
    drain("ill2_drain");
    send(mk(32'h7F000000, 32'h7F000000, 4'd2, 4'd7, 32'h7F800000, 4'b0010, 1'b0));
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge Clk); n++; end while (!out_valid && n < 20);
    check("ovf_wait", 32'(out_valid), 32'd1);
    flag_clr = 1'b1;
    @(posedge Clk);
    #1;
    flag_clr = 1'b0;
    check("sticky_ovf_kept", 32'(sticky_flags[1]), 32'(exp_sticky[0]));
    check("sticky_ill_cleared", 32'(sticky_flags[3]), 32'd0);
    drain("ovf_drain");

    // reset with 3 queued and 2 in the pipe
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(mk(32'h3F800000, 32'h3F800000, 4'd0, 4'(8 + i), 32'h40000000, 4'b0000, 1'b1));
    in_valid = 1'b0;
    tick(2);
    check("mid_fifo_count", 32'(fifo_count), 32'd3);
    #2;
    Rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    check("mid_rst_output", FPU_Output, 32'd0);
    check("mid_rst_out_tag", 32'(out_tag), 32'd0);
    sb.delete();
    tick(1);
    Rst = 1'b0;
    out_ready = 1'b1;
    tick(8);
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    t = mk(32'h3F800000, 32'h3F800000, 4'd0, 4'd13, 32'h40000000, 4'b0000, 1'b1);
    t.lat = 1'b1;
    send(t);
    in_valid = 1'b0;
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
